// File: rtl/rv_instr_encoder_if.sv
// Request/response bundle for rv_instr_encoder: valid/ready request with instruction fields,
// valid/ready response carrying the encoded word and its status flags.
interface rv_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic        out_err;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_illegal, out_err
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_illegal, out_err
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I instruction encoder with a 2-entry output buffer.
// Optional immediate range checking is built when RV_ENC_IMM_CHECK_EN is defined.
module rv_instr_encoder #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  rv_instr_encoder_if.slave  bus,
  output logic [COUNT_W-1:0] enc_count
);

  localparam logic [3:0] KindLw   = 4'd0;
  localparam logic [3:0] KindSw   = 4'd1;
  localparam logic [3:0] KindAdd  = 4'd2;
  localparam logic [3:0] KindSub  = 4'd3;
  localparam logic [3:0] KindAddi = 4'd4;
  localparam logic [3:0] KindBeq  = 4'd5;
  localparam logic [3:0] KindJal  = 4'd6;
  localparam logic [3:0] KindJalr = 4'd7;
  localparam logic [3:0] KindLui  = 4'd8;

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] enc_instr;
  logic        enc_illegal;
  logic        enc_err;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  always_comb begin
    enc_instr   = 32'h0000_0013;
    enc_illegal = 1'b0;
    case (bus.in_kind)
      KindLw:   enc_instr = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      KindSw:   enc_instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      KindAdd:  enc_instr = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      KindSub:  enc_instr = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      KindAddi: enc_instr = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      KindBeq:  enc_instr = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      KindJal:  enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      KindJalr: enc_instr = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      KindLui:  enc_instr = {imm[19:0], rd, 7'b0110111};
      default:  enc_illegal = 1'b1;
    endcase
  end

`ifdef RV_ENC_IMM_CHECK_EN
  logic fits_i, fits_b, fits_j, fits_u;

  // Sign-extension checks: every bit above the field's top bit must equal it.
  assign fits_i = (imm[31:11] == {21{imm[11]}});
  assign fits_b = (imm[31:12] == {20{imm[12]}}) && !imm[0];
  assign fits_j = (imm[31:20] == {12{imm[20]}}) && !imm[0];
  assign fits_u = (imm[31:20] == 12'h000);

  always_comb begin
    enc_err = 1'b0;
    case (bus.in_kind)
      KindLw, KindSw, KindAddi, KindJalr: enc_err = !fits_i;
      KindBeq:                            enc_err = !fits_b;
      KindJal:                            enc_err = !fits_j;
      KindLui:                            enc_err = !fits_u;
      default:                            enc_err = 1'b0;
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = ^imm[31:21];
  assign enc_err    = 1'b0;
`endif

  logic [31:0]        instr_q   [2];
  logic               illegal_q [2];
  logic               err_q     [2];
  logic [1:0]         count_q, count_d;
  logic               rd_ptr_q, wr_ptr_q;
  logic [COUNT_W-1:0] enc_count_q;
  logic               push, pop;

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      enc_count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        instr_q[wr_ptr_q]   <= enc_instr;
        illegal_q[wr_ptr_q] <= enc_illegal;
        err_q[wr_ptr_q]     <= enc_err;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q    <= ~rd_ptr_q;
        enc_count_q <= enc_count_q + COUNT_W'(1);
      end
    end
  end

  // Gate the head fields so stale slots never show while the buffer is empty.
  assign bus.out_instr   = bus.out_valid ? instr_q[rd_ptr_q] : 32'h0000_0000;
  assign bus.out_illegal = bus.out_valid && illegal_q[rd_ptr_q];
  assign bus.out_err     = bus.out_valid && err_q[rd_ptr_q];
  assign enc_count       = enc_count_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed steps followed by random traffic, checked against a
// queue-based model that encodes words straight from the RV32I field layout.
module tb_rv_instr_encoder;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] enc_count;

  always #5 clk = ~clk;

  rv_instr_encoder_if bus ();

  rv_instr_encoder #(.COUNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .enc_count (enc_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        illegal;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int unsigned exp_cnt;
  int          vectors;
  int          miscompares;

  function automatic logic [31:0] ref_word(int unsigned kind, int unsigned rd, int unsigned rs1,
                                           int unsigned rs2, int unsigned u);
    case (kind)
      0: return ((u & 32'hfff) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
      1: return (((u >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                | ((u & 32'h1f) << 7) | 32'h23;
      2: return (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
      3: return 32'h4000_0000 | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
      4: return ((u & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
      5: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2 << 20)
                | (rs1 << 15) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      6: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21)
                | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) | (rd << 7) | 32'h6f;
      7: return ((u & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      8: return ((u & 32'hfffff) << 12) | (rd << 7) | 32'h37;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic ref_err(int unsigned kind, int imm);
`ifdef RV_ENC_IMM_CHECK_EN
    case (kind)
      0, 1, 4, 7: return !(imm >= -2048 && imm <= 2047);
      5:          return !(imm >= -4096 && imm <= 4094 && (imm & 1) == 0);
      6:          return !(imm >= -1048576 && imm <= 1048574 && (imm & 1) == 0);
      8:          return (unsigned'(imm) >> 20) != 0;
      default:    return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check against the model at the falling edge, then advance the model.
  task automatic cycle();
    bit   push, pop;
    exp_t e;
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_instr", bus.out_instr, q[0].instr);
      chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].illegal));
      chk("out_err", 32'(bus.out_err), 32'(q[0].err));
    end
    chk("enc_count", 32'(enc_count), exp_cnt);
    push = !reset && bus.in_valid && (q.size() < 2);
    pop  = !reset && (q.size() != 0) && bus.out_ready;
    if (push) begin
      e.instr   = ref_word(bus.in_kind, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
      e.illegal = (bus.in_kind > 8);
      e.err     = ref_err(bus.in_kind, int'(bus.in_imm));
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
      if (push) q.push_back(e);
    end
    #1;
  endtask

  task automatic send(int unsigned kind, int unsigned rd, int unsigned rs1, int unsigned rs2,
                      int imm);
    bus.in_valid = 1'b1;
    bus.in_kind  = 4'(kind);
    bus.in_rd    = 5'(rd);
    bus.in_rs1   = 5'(rs1);
    bus.in_rs2   = 5'(rs2);
    bus.in_imm   = 32'(imm);
    cycle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int unsigned base;
    int          imm;
    vectors      = 0;
    miscompares  = 0;
    exp_cnt      = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_kind  = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_enc_count", 32'(enc_count), 32'h0);

    bus.out_ready = 1'b1;
    send(4, 1, 0, 0, 5);
    chk("addi", bus.out_instr, 32'h0050_0093);
    cycle();
    chk("count_after_addi", 32'(enc_count), 32'h1);

    send(2, 3, 1, 2, 0);
    chk("add", bus.out_instr, 32'h0020_81B3);
    send(3, 3, 1, 2, 0);
    chk("sub", bus.out_instr, 32'h4020_81B3);

    send(0, 2, 1, 0, 8);
    chk("lw", bus.out_instr, 32'h0080_A103);
    send(1, 0, 1, 2, 4);
    chk("sw", bus.out_instr, 32'h0020_A223);
    send(5, 0, 1, 2, 8);
    chk("beq", bus.out_instr, 32'h0020_8463);
    send(6, 1, 0, 0, 16);
    chk("jal", bus.out_instr, 32'h0100_00EF);
    send(7, 0, 1, 0, 0);
    chk("jalr", bus.out_instr, 32'h0000_8067);
    send(8, 5, 0, 0, 32'h12345);
    chk("lui", bus.out_instr, 32'h1234_52B7);
    cycle();

    // Stalled consumer: third request must be refused.
    bus.out_ready = 1'b0;
    base = exp_cnt;
    send(2, 1, 1, 2, 0);
    send(2, 2, 1, 2, 0);
    send(2, 3, 1, 2, 0);
    chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
    chk("stall_head", bus.out_instr, 32'h0020_80B3);
    repeat (3) cycle();
    bus.out_ready = 1'b1;
    cycle();
    chk("drain_second", bus.out_instr, 32'h0020_8133);
    repeat (2) cycle();
    chk("drain_count", 32'(enc_count), (base + 2) % (1 << CW));
    chk("drain_in_ready", 32'(bus.in_ready), 32'h1);

    send(12, 7, 7, 7, 32'h7ff);
    chk("illegal_instr", bus.out_instr, 32'h0000_0013);
    chk("illegal_flag", 32'(bus.out_illegal), 32'h1);
    cycle();

`ifdef RV_ENC_IMM_CHECK_EN
    send(4, 1, 0, 0, 4096);
    chk("imm_err_flag", 32'(bus.out_err), 32'h1);
    chk("imm_err_instr", bus.out_instr, 32'h0000_0093);
    cycle();
`endif

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       imm = int'($urandom_range(0, 10000)) - 5000;
        1:       imm = int'($urandom_range(0, 4200000)) - 2100000;
        2:       imm = int'($urandom_range(0, 4095)) - 2048;
        default: imm = int'($urandom);
      endcase
      reset         = ($urandom_range(0, 59) == 0);
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_kind   = 4'($urandom_range(0, 15));
      bus.in_rd     = 5'($urandom);
      bus.in_rs1    = 5'($urandom);
      bus.in_rs2    = 5'($urandom);
      bus.in_imm    = 32'(imm);
      bus.out_ready = $urandom_range(0, 2) != 0;
      cycle();
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Streaming RV32I instruction encoder: takes instruction class plus register/immediate fields and emits the 32-bit machine word that the processor's control-unit decode path consumes.
- Used as the program-generation front end for instruction-memory loading and for self-checking decode benches.
- Valid/ready input and output, with a 2-entry output buffer so a stalled consumer never drops words.

Parameters:
- COUNT_W, 16, width of the encoded-word counter enc_count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  encoder can accept a request this cycle
- in_kind  input  4  0 LW, 1 SW, 2 ADD, 3 SUB, 4 ADDI, 5 BEQ, 6 JAL, 7 JALR, 8 LUI; 9-15 illegal
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_imm  input  32  signed byte offset or immediate; for LUI, the upper value in imm[19:0]
- out_valid  output  1  encoded word available
- out_ready  input  1  consumer accepts the word
- out_instr  output  32  encoded instruction
- out_illegal  output  1  in_kind was illegal; out_instr is 0x00000013 (NOP)
- out_err  output  1  immediate range fault (only with IMM_CHECK_EN)
- enc_count  output  COUNT_W  number of completed output handshakes

Behaviour:
- Reset, synchronous: buffer empty, out_valid=0, out_instr=0, out_illegal=0, out_err=0, enc_count=0, in_ready=1 in the cycle after reset.
- A request is accepted when in_valid && in_ready is high at a rising edge. The encoding is computed combinationally and stored in the buffer.
- Latency: the word is on out_instr with out_valid=1 in the cycle after acceptance.
- in_ready = (buffer count < 2). It is registered-derived, with no combinational path from out_ready.
- Output handshake: the head word is popped when out_valid && out_ready. Head fields stay stable while out_valid=1 and out_ready=0.
- Same-cycle push and pop with count 1: count stays 1, order is preserved, and the new word becomes head next cycle.
- At count 2, in_ready=0, so no push can occur. A pop in that cycle gives count 1 and in_ready=1 next cycle.
- At count 0, a pop cannot occur (out_valid=0).
- enc_count increments by 1 per output handshake and wraps from 2^COUNT_W-1 to 0.
- Encodings (opcode / funct3 / funct7):
  - LW: I-type 0000011/010.
  - SW: S-type 0100011/010, imm[11:5] in bits 31:25, imm[4:0] in bits 11:7.
  - ADD: R-type 0110011/000/0000000.
  - SUB: R-type 0110011/000/0100000.
  - ADDI: I-type 0010011/000.
  - BEQ: B-type 1100011/000, imm[12|10:5] in bits 31:25, imm[4:1|11] in bits 11:7.
  - JAL: J-type 1101111, imm[20|10:1|11|19:12] in bits 31:12.
  - JALR: I-type 1100111/000.
  - LUI: U-type 0110111, imm[19:0] in bits 31:12.
- Fields unused by a format are ignored (for example, in_rs2 for I-type).
- Illegal kind: the word is still accepted and buffered, with out_instr=0x00000013 and out_illegal=1.
- Reset asserted mid-stream empties the buffer. Words not yet popped are discarded and not counted.

Optional Feature:
- Macro: RV_ENC_IMM_CHECK_EN.
- When defined, out_err=1 on the buffered word if the immediate does not fit its format:
  - I/S: -2048..2047.
  - B: -4096..4094 and even.
  - J: -1048576..1048574 and even.
  - LUI: imm[31:20]=0.
- When defined, the word is still encoded from truncated bits.
- When undefined, out_err is tied to 0 and no check logic is built.

Test Plan:
- Reset, then ADDI rd=1 rs1=0 imm=5 with out_ready=1 -> out_instr=0x00500093 one cycle later; enc_count=1.
- Back-to-back ADD (1,2 -> 3) then SUB, with out_ready=1 -> 0x002081B3 then 0x402081B3 on consecutive cycles.
- LW rd=2 rs1=1 imm=8, SW rs2=2 rs1=1 imm=4, BEQ rs1=1 rs2=2 imm=8 -> 0x0080A103, 0x0020A223, 0x00208463.
- JAL rd=1 imm=16, JALR rd=0 rs1=1 imm=0, LUI rd=5 imm=0x12345 -> 0x010000EF, 0x00008067, 0x123452B7.
- out_ready=0 and push 3 requests -> in_ready drops after 2 accepts. Then release out_ready -> both words drain in order, head stable while stalled; enc_count +2.
- in_kind=12 -> out_instr=0x00000013, out_illegal=1. With the macro defined, ADDI imm=4096 -> out_err=1.
